// File: rtl/ibex_mem_responder.sv
// Responder for the Ibex instruction/data req/gnt/rvalid buses: round-robin
// arbitration onto one word RAM, plus host mailbox and halt registers.
module ibex_mem_responder #(
  parameter int unsigned Depth    = 16384,
  parameter logic [31:0] HostAddr = 32'h0002_0000,
  parameter logic [31:0] HaltAddr = 32'h0002_0004
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        instr_req_i,
  input  logic [31:0] instr_addr_i,
  output logic        instr_gnt_o,
  output logic        instr_rvalid_o,
  output logic [31:0] instr_rdata_o,
  output logic        instr_err_o,
  input  logic        data_req_i,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  output logic        data_gnt_o,
  output logic        data_rvalid_o,
  output logic [31:0] data_rdata_o,
  output logic        data_err_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  output logic        host_wr_valid_o,
  output logic [31:0] host_wr_data_o,
  output logic        sim_halt_o,
  output logic [31:0] halt_code_o,
  output logic        proto_err_o
);

  localparam logic [1:0]  KindRam   = 2'd0;
  localparam logic [1:0]  KindHost  = 2'd1;
  localparam logic [1:0]  KindHalt  = 2'd2;
  localparam logic [1:0]  KindErr   = 2'd3;
  localparam logic        PortInstr = 1'b0;
  localparam logic        PortData  = 1'b1;
  localparam logic [32:0] RamLimit  = 33'(Depth) << 2;

  logic        last_grant;
  logic        tag_valid;
  logic        tag_port;
  logic [1:0]  tag_kind;

  logic        grant_instr;
  logic        grant_data;
  logic        grant_any;
  logic        sel_port;
  logic [31:0] sel_addr;
  logic [1:0]  sel_kind;
  logic        resp_valid;
  logic        resp_ram;
  logic        ram_rsp_expected;

  // Round-robin: on contention, grant the port that did not win last time.
  always_comb begin
    grant_instr = 1'b0;
    grant_data  = 1'b0;
    if (!reset) begin
      if (instr_req_i && data_req_i) begin
        if (last_grant == PortInstr) grant_data = 1'b1;
        else                         grant_instr = 1'b1;
      end else begin
        grant_instr = instr_req_i;
        grant_data  = data_req_i;
      end
    end
  end

  assign grant_any   = grant_instr | grant_data;
  assign sel_port    = grant_data ? PortData : PortInstr;
  assign sel_addr    = grant_data ? data_addr_i : instr_addr_i;
  assign instr_gnt_o = grant_instr;
  assign data_gnt_o  = grant_data;

  // Address decode; host registers are reachable from the data port only.
  always_comb begin
    sel_kind = KindErr;
    if ({1'b0, sel_addr} < RamLimit) begin
      sel_kind = KindRam;
    end else if (grant_data && (sel_addr[31:2] == HostAddr[31:2])) begin
      sel_kind = KindHost;
    end else if (grant_data && (sel_addr[31:2] == HaltAddr[31:2])) begin
      sel_kind = KindHalt;
    end
  end

  assign mem_req_o   = grant_any && (sel_kind == KindRam);
  assign mem_we_o    = mem_req_o && grant_data && data_we_i;
  assign mem_be_o    = grant_data ? data_be_i : 4'hF;
  assign mem_addr_o  = sel_addr;
  assign mem_wdata_o = grant_data ? data_wdata_i : 32'h0;

  // Responses come straight from the in-flight tag; reset suppresses them.
  assign resp_valid       = tag_valid && !reset;
  assign resp_ram         = tag_kind == KindRam;
  assign ram_rsp_expected = tag_valid && resp_ram;

  assign instr_rvalid_o = resp_valid && (tag_port == PortInstr);
  assign data_rvalid_o  = resp_valid && (tag_port == PortData);
  assign instr_err_o    = instr_rvalid_o && (tag_kind == KindErr);
  assign data_err_o     = data_rvalid_o && (tag_kind == KindErr);
  assign instr_rdata_o  = (instr_rvalid_o && resp_ram) ? mem_rdata_i : 32'h0;
  assign data_rdata_o   = (data_rvalid_o && resp_ram) ? mem_rdata_i : 32'h0;

  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant      <= PortInstr;
      tag_valid       <= 1'b0;
      tag_port        <= PortInstr;
      tag_kind        <= KindRam;
      host_wr_valid_o <= 1'b0;
      host_wr_data_o  <= 32'h0;
      sim_halt_o      <= 1'b0;
      halt_code_o     <= 32'h0;
      proto_err_o     <= 1'b0;
    end else begin
      tag_valid <= grant_any;
      if (grant_any) begin
        last_grant <= sel_port;
        tag_port   <= sel_port;
        tag_kind   <= sel_kind;
      end
      host_wr_valid_o <= grant_data && data_we_i && (sel_kind == KindHost);
      if (grant_data && data_we_i && (sel_kind == KindHost)) begin
        host_wr_data_o <= data_wdata_i;
      end
      if (grant_data && data_we_i && (sel_kind == KindHalt)) begin
        sim_halt_o  <= 1'b1;
        halt_code_o <= data_wdata_i;
      end
      if (mem_rvalid_i != ram_rsp_expected) begin
        proto_err_o <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ibex_mem_responder.sv
// Scoreboard bench for ibex_mem_responder with a simple one-cycle word RAM.
module tb_ibex_mem_responder;

  localparam logic [31:0] HostAddr = 32'h0002_0000;
  localparam logic [31:0] HaltAddr = 32'h0002_0004;
  localparam logic [31:0] RamBytes = 32'h0001_0000;

  typedef struct packed {
    logic        port;
    logic [31:0] rdata;
    logic        err;
  } rsp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        instr_req = 1'b0;
  logic [31:0] instr_addr = 32'h0;
  logic        instr_gnt_o, instr_rvalid_o, instr_err_o;
  logic [31:0] instr_rdata_o;
  logic        data_req = 1'b0;
  logic        data_we = 1'b0;
  logic [3:0]  data_be = 4'h0;
  logic [31:0] data_addr = 32'h0;
  logic [31:0] data_wdata = 32'h0;
  logic        data_gnt_o, data_rvalid_o, data_err_o;
  logic [31:0] data_rdata_o;
  logic        mem_req_o, mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = 32'h0;
  logic        host_wr_valid_o, sim_halt_o, proto_err_o;
  logic [31:0] host_wr_data_o, halt_code_o;

  logic [31:0] ram    [0:16383];
  logic [31:0] shadow [0:16383];
  rsp_t        sb [$];
  logic        exp_last = 1'b0;
  int          vectors = 0;
  int          miscompares = 0;

  ibex_mem_responder dut (
    .clk(clk), .reset(reset),
    .instr_req_i(instr_req), .instr_addr_i(instr_addr), .instr_gnt_o(instr_gnt_o),
    .instr_rvalid_o(instr_rvalid_o), .instr_rdata_o(instr_rdata_o), .instr_err_o(instr_err_o),
    .data_req_i(data_req), .data_we_i(data_we), .data_be_i(data_be), .data_addr_i(data_addr),
    .data_wdata_i(data_wdata), .data_gnt_o(data_gnt_o), .data_rvalid_o(data_rvalid_o),
    .data_rdata_o(data_rdata_o), .data_err_o(data_err_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata),
    .host_wr_valid_o(host_wr_valid_o), .host_wr_data_o(host_wr_data_o),
    .sim_halt_o(sim_halt_o), .halt_code_o(halt_code_o), .proto_err_o(proto_err_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // RAM: one-cycle latency, writes return zero data.
  always @(posedge clk) begin
    mem_rvalid <= mem_req_o;
    if (mem_req_o) begin
      if (mem_we_o) begin
        for (int b = 0; b < 4; b++)
          if (mem_be_o[b]) ram[mem_addr_o[15:2]][8*b +: 8] <= mem_wdata_o[8*b +: 8];
        mem_rdata <= 32'h0;
      end else begin
        mem_rdata <= ram[mem_addr_o[15:2]];
      end
    end
  end

  // Response monitor: each rvalid pops the oldest expected response.
  always @(negedge clk) begin
    rsp_t r;
    if (instr_rvalid_o || data_rvalid_o) begin
      if (sb.size() == 0) begin
        chk("unexpected_rvalid", 32'(1), 32'(0));
      end else begin
        r = sb.pop_front();
        chk("rsp_both_valid", 32'(instr_rvalid_o && data_rvalid_o), 32'(0));
        chk("rsp_port", 32'(data_rvalid_o), 32'(r.port));
        chk("rsp_rdata", r.port ? data_rdata_o : instr_rdata_o, r.rdata);
        chk("rsp_err", 32'(r.port ? data_err_o : instr_err_o), 32'(r.err));
      end
    end else if (sb.size() > 1) begin
      chk("missing_rvalid", 32'(0), 32'(1));
      void'(sb.pop_front());
    end
  end

  // Drive one cycle of requests, predict grant/decode, push expected response.
  task automatic step(input logic ir, input logic [31:0] ia, input logic dr, input logic dw,
                      input logic [3:0] db, input logic [31:0] da, input logic [31:0] dd);
    logic gi, gd, is_ram, is_reg;
    rsp_t r;
    @(posedge clk); #1;
    instr_req = ir; instr_addr = ia;
    data_req = dr; data_we = dw; data_be = db; data_addr = da; data_wdata = dd;
    gi = 1'b0; gd = 1'b0;
    if (ir && dr) begin
      if (exp_last) gi = 1'b1;
      else          gd = 1'b1;
    end else begin
      gi = ir; gd = dr;
    end
    is_ram = 1'b0;
    if (gi) begin
      exp_last = 1'b0;
      is_ram = ia < RamBytes;
      r.port = 1'b0;
      r.rdata = is_ram ? shadow[ia[15:2]] : 32'h0;
      r.err = !is_ram;
      sb.push_back(r);
    end
    if (gd) begin
      exp_last = 1'b1;
      is_ram = da < RamBytes;
      is_reg = (da[31:2] == HostAddr[31:2]) || (da[31:2] == HaltAddr[31:2]);
      r.port = 1'b1;
      r.rdata = (is_ram && !dw) ? shadow[da[15:2]] : 32'h0;
      r.err = !is_ram && !is_reg;
      if (is_ram && dw)
        for (int b = 0; b < 4; b++)
          if (db[b]) shadow[da[15:2]][8*b +: 8] = dd[8*b +: 8];
      sb.push_back(r);
    end
    @(negedge clk);
    chk("instr_gnt", 32'(instr_gnt_o), 32'(gi));
    chk("data_gnt", 32'(data_gnt_o), 32'(gd));
    chk("mem_req", 32'(mem_req_o), 32'(is_ram));
    if (is_ram) chk("mem_we", 32'(mem_we_o), 32'(gd && dw));
  endtask

  task automatic idle();
    step(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
  endtask

  initial begin
    for (int i = 0; i < 16384; i++) begin
      ram[i] = 32'h0;
      shadow[i] = 32'h0;
    end
    ram[32] = 32'h0000_0013;
    shadow[32] = 32'h0000_0013;

    // Reset with both ports requesting: nothing may be granted.
    instr_req = 1'b1; data_req = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_instr_gnt", 32'(instr_gnt_o), 32'(0));
    chk("rst_data_gnt", 32'(data_gnt_o), 32'(0));
    chk("rst_mem_req", 32'(mem_req_o), 32'(0));
    chk("rst_rvalid", 32'(instr_rvalid_o | data_rvalid_o), 32'(0));
    chk("rst_flags", 32'({host_wr_valid_o, sim_halt_o, proto_err_o}), 32'(0));
    chk("rst_halt_code", halt_code_o, 32'h0);
    @(posedge clk); #1;
    reset = 1'b0; instr_req = 1'b0; data_req = 1'b0;

    // Single fetch of word 32.
    step(1'b1, 32'h80, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    idle();
    chk("fetch_rvalid", 32'(instr_rvalid_o), 32'(1));
    chk("fetch_rdata", instr_rdata_o, 32'h0000_0013);

    // Contention for six cycles: grants alternate starting with data.
    for (int i = 0; i < 6; i++)
      step(1'b1, 32'h80 + 32'(4 * i), 1'b1, 1'b0, 4'hF, 32'h200 + 32'(4 * i), 32'h0);
    idle();

    // Partial-byte write then read back.
    step(1'b0, 32'h0, 1'b1, 1'b1, 4'b0011, 32'h100, 32'hAABB_CCDD);
    step(1'b0, 32'h0, 1'b1, 1'b0, 4'hF, 32'h100, 32'h0);
    idle();
    chk("be_read_rdata", data_rdata_o, 32'h0000_CCDD);

    // Mailbox write: one pulse carrying the data, no RAM access.
    step(1'b0, 32'h0, 1'b1, 1'b1, 4'h1, HostAddr, 32'd42);
    idle();
    chk("host_wr_valid", 32'(host_wr_valid_o), 32'(1));
    chk("host_wr_data", host_wr_data_o, 32'd42);
    chk("host_rvalid", 32'(data_rvalid_o), 32'(1));
    idle();
    chk("host_wr_pulse_end", 32'(host_wr_valid_o), 32'(0));

    // Decode errors on both ports.
    step(1'b1, HaltAddr, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    step(1'b0, 32'h0, 1'b1, 1'b0, 4'hF, 32'h0001_0000, 32'h0);
    idle();
    idle();
    chk("proto_err", 32'(proto_err_o), 32'(0));

    // Halt write followed immediately by reset.
    step(1'b0, 32'h0, 1'b1, 1'b1, 4'hF, HaltAddr, 32'd7);
    @(posedge clk); #1;
    reset = 1'b1; data_req = 1'b0; data_we = 1'b0;
    @(negedge clk);
    chk("halt_rvalid_in_reset", 32'(data_rvalid_o), 32'(0));
    chk("halt_set", 32'(sim_halt_o), 32'(1));
    chk("halt_code", halt_code_o, 32'd7);
    sb.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    exp_last = 1'b0;
    @(negedge clk);
    chk("post_rst_rvalid", 32'(data_rvalid_o), 32'(0));
    chk("post_rst_halt", 32'(sim_halt_o), 32'(0));
    chk("post_rst_halt_code", halt_code_o, 32'h0);

    idle();
    idle();
    chk("sb_drained", 32'(sb.size()), 32'(0));
    chk("proto_err_end", 32'(proto_err_o), 32'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ibex_mem_responder.md
Name: ibex_mem_responder

Overview:
- Responder end of the Ibex instruction and data request/grant/rvalid bus.
- Arbitrates the core's instruction-fetch and data ports onto the single-port word RAM (Depth 16384).
- Decodes two memory-mapped host registers: a console/write mailbox and a halt/exit register.
- Returns rvalid, rdata and err to the originating port exactly one cycle after grant, so the testbench BFM no longer hand-codes the bus.

Parameters:
- Depth, 16384: RAM depth in 32-bit words; RAM window is 0 .. Depth*4-1.
- HostAddr, 32'h0002_0000: data-port write here emits a host_wr pulse.
- HaltAddr, 32'h0002_0004: data-port write here sets sim_halt and latches halt_code.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous active-high reset
- instr_req_i  in  1  fetch request
- instr_addr_i  in  32  fetch byte address
- instr_gnt_o  out  1  fetch grant (combinational)
- instr_rvalid_o  out  1  fetch response valid
- instr_rdata_o  out  32  fetch data
- instr_err_o  out  1  fetch error
- data_req_i  in  1  data request
- data_we_i  in  1  write enable
- data_be_i  in  4  byte enables
- data_addr_i  in  32  data byte address
- data_wdata_i  in  32  write data
- data_gnt_o  out  1  data grant (combinational)
- data_rvalid_o  out  1  data response valid
- data_rdata_o  out  32  data read data
- data_err_o  out  1  data error
- mem_req_o  out  1  RAM request
- mem_we_o  out  1  RAM write
- mem_be_o  out  4  RAM byte enables
- mem_addr_o  out  32  RAM byte address (passed through)
- mem_wdata_o  out  32  RAM write data
- mem_rvalid_i  in  1  RAM response valid
- mem_rdata_i  in  32  RAM read data
- host_wr_valid_o  out  1  one-cycle pulse, mailbox write
- host_wr_data_o  out  32  mailbox write data
- sim_halt_o  out  1  sticky halt flag
- halt_code_o  out  32  value written to HaltAddr
- proto_err_o  out  1  sticky: mem_rvalid_i disagreed with an expected RAM response

Behaviour:
- Reset values:
  - All rvalid, err and gnt outputs are 0.
  - mem_req_o, host_wr_valid_o, sim_halt_o and proto_err_o are 0.
  - rdata and halt_code are 0.
  - last_grant = instr.
  - The in-flight tag is invalid.
- Reset mid-operation: any in-flight response is dropped; no rvalid is issued in the cycle after reset deasserts.
- Grant:
  - Combinational, same cycle as req. At most one port is granted per cycle; a grant is possible every cycle.
  - Only instr requesting: grant instr. Only data requesting: grant data.
  - Both requesting: grant the port not named by last_grant (round-robin). last_grant updates on every grant.
  - No grant while reset is high.
- Decode of the granted request:
  - RAM: addr < Depth*4.
  - HOST: data port, addr == HostAddr.
  - HALT: data port, addr == HaltAddr.
  - Anything else, and instr-port HOST/HALT addresses, is ERR.
  - Address bits [1:0] are ignored for decode.
- RAM kind:
  - mem_req_o=1 in the grant cycle, with we/be/addr/wdata from the granted port.
  - Instr port drives we=0, be=4'hF.
  - mem_* outputs are combinational from the grant mux.
- Non-RAM kinds: mem_req_o=0.
- In-flight tag (registered at grant): {valid, port, kind}.
- Response (cycle N+1 after grant in cycle N):
  - Assert the owning port's rvalid for exactly one cycle.
  - RAM: rdata = mem_rdata_i, err=0.
  - HOST/HALT: rdata=0, err=0; reads are legal and return 0.
  - ERR: rdata=0, err=1; nothing is written.
  - The non-owning port's rvalid=0. Back-to-back grants give back-to-back responses.
- proto_err_o sets if mem_rvalid_i != (tag.valid && tag.kind==RAM) in any cycle.
- HOST write: host_wr_valid_o pulses in cycle N+1 with host_wr_data_o = data_wdata_i captured at grant, independent of be.
- HALT write:
  - In cycle N+1, set sim_halt_o=1 and halt_code_o = wdata.
  - Later HALT writes update halt_code; sim_halt remains 1 until reset.
  - Requests continue to be served after halt.
- Simultaneous grant and response in the same cycle is normal pipelined operation.

Test Plan:
- Instr-only fetch of 0x80 with RAM word 32 = 0x00000013 -> instr_gnt same cycle; instr_rvalid next cycle with rdata 0x00000013, err=0.
- Both ports request every cycle for 6 cycles, after reset -> grants alternate data,instr,data,...; each rvalid lands on the correct port one cycle after its grant.
- Data write be=4'b0011 wdata=0xAABBCCDD to 0x100, then read 0x100 (RAM pre-zeroed) -> read returns 0x0000CCDD.
- Data write 42 to 0x0002_0000 -> host_wr_valid one pulse with data 42, data_rvalid next cycle, mem_req_o stays 0.
- Data read from 0x0001_0000 and fetch from 0x0002_0004 -> each gets rvalid with err=1 and rdata 0; RAM untouched.
- Write 7 to HaltAddr, assert reset the very next cycle -> no data_rvalid is seen; sim_halt and halt_code return to 0.
